// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes multiplexed active-low 7-segment scan lines back into BCD frames
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  an_i,
    input  logic [6:0]  seg_i,
    output logic [31:0] digits_o,
    output logic [7:0]  blank_mask_o,
    output logic [7:0]  err_mask_o,
    output logic [5:0]  minutes_o,
    output logic [5:0]  seconds_o,
    output logic        time_valid_o,
    output logic        frame_valid_o,
    output logic        frame_tick_o,
    output logic        multi_sel_err_o
);
    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]    an_q, an_p_q;
    logic [6:0]    seg_q, seg_p_q;
    logic [SW-1:0] settle_q, settle_d;
    logic          sampled_q, sampled_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    seen_q, seen_d;
    logic [31:0]   work_q, work_d;
    logic [31:0]   digits_q, digits_d;
    logic [7:0]    blank_q, blank_d, err_q, err_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic          tv_q, tv_d, fv_q, fv_d, tick_q, tick_d, mse_q, mse_d;

    logic       changed, sample, one_hot, multi, capture;
    logic [7:0] low;
    logic [2:0] idx;
    logic [3:0] nib;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: seg_decode = 4'd0;
            7'b1111001: seg_decode = 4'd1;
            7'b0100100: seg_decode = 4'd2;
            7'b0110000: seg_decode = 4'd3;
            7'b0011001: seg_decode = 4'd4;
            7'b0010010: seg_decode = 4'd5;
            7'b0000010: seg_decode = 4'd6;
            7'b1111000: seg_decode = 4'd7;
            7'b0000000: seg_decode = 4'd8;
            7'b0010000: seg_decode = 4'd9;
            7'b1111111: seg_decode = 4'hF;
            default:    seg_decode = 4'hE;
        endcase
    endfunction

    function automatic logic [5:0] times10_plus(input logic [3:0] hi, input logic [3:0] lo);
        times10_plus = ({2'b00, hi} << 3) + ({2'b00, hi} << 1) + {2'b00, lo};
    endfunction

    always_comb begin
        changed = (an_q != an_p_q) || (seg_q != seg_p_q);
        // The previous-cycle copy is the value whose stability the settle counter measured
        sample  = (settle_q == SETTLE_MAX) && !sampled_q;
        low     = ~an_p_q;
        one_hot = (low != 8'd0) && ((low & (low - 8'd1)) == 8'd0);
        multi   = (low != 8'd0) && !one_hot;
        capture = sample && one_hot;
        nib     = seg_decode(seg_p_q);
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (low[i]) idx = 3'(i);
        end

        settle_d  = changed ? '0 : ((settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1);
        sampled_d = changed ? 1'b0 : (sample ? 1'b1 : sampled_q);
        to_d      = to_q;
        seen_d    = seen_q;
        work_d    = work_q;
        digits_d  = digits_q;
        blank_d   = blank_q;
        err_d     = err_q;
        min_d     = min_q;
        sec_d     = sec_q;
        tv_d      = tv_q;
        fv_d      = fv_q;
        tick_d    = 1'b0;
        mse_d     = sample && multi;

        if (capture) begin
            to_d = '0;
            if (seen_q[idx]) begin
                for (int j = 0; j < 8; j++) begin
                    digits_d[4*j +: 4] = seen_q[j] ? work_q[4*j +: 4] : 4'hF;
                    blank_d[j]         = (digits_d[4*j +: 4] == 4'hF);
                    err_d[j]           = (digits_d[4*j +: 4] == 4'hE);
                end
                min_d  = times10_plus(digits_d[15:12], digits_d[11:8]);
                sec_d  = times10_plus(digits_d[7:4], digits_d[3:0]);
                tv_d   = (digits_d[15:12] <= 4'd5) && (digits_d[11:8] <= 4'd9) &&
                         (digits_d[7:4] <= 4'd5) && (digits_d[3:0] <= 4'd9);
                tick_d = 1'b1;
                fv_d   = 1'b1;
                seen_d = 8'(8'd1 << idx);
            end else begin
                seen_d = seen_q | 8'(8'd1 << idx);
            end
            work_d[{idx, 2'b00} +: 4] = nib;
        end else if (to_q == TO_MAX) begin
            fv_d   = 1'b0;
            seen_d = 8'd0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            an_q      <= 8'hFF;
            an_p_q    <= 8'hFF;
            seg_q     <= 7'h7F;
            seg_p_q   <= 7'h7F;
            settle_q  <= '0;
            sampled_q <= 1'b0;
            to_q      <= '0;
            seen_q    <= 8'd0;
            work_q    <= 32'hFFFF_FFFF;
            digits_q  <= 32'hFFFF_FFFF;
            blank_q   <= 8'hFF;
            err_q     <= 8'd0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            tv_q      <= 1'b0;
            fv_q      <= 1'b0;
            tick_q    <= 1'b0;
            mse_q     <= 1'b0;
        end else begin
            an_q      <= an_i;
            an_p_q    <= an_q;
            seg_q     <= seg_i;
            seg_p_q   <= seg_q;
            settle_q  <= settle_d;
            sampled_q <= sampled_d;
            to_q      <= to_d;
            seen_q    <= seen_d;
            work_q    <= work_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            tv_q      <= tv_d;
            fv_q      <= fv_d;
            tick_q    <= tick_d;
            mse_q     <= mse_d;
        end
    end

    assign digits_o        = digits_q;
    assign blank_mask_o    = blank_q;
    assign err_mask_o      = err_q;
    assign minutes_o       = min_q;
    assign seconds_o       = sec_q;
    assign time_valid_o    = tv_q;
    assign frame_valid_o   = fv_q;
    assign frame_tick_o    = tick_q;
    assign multi_sel_err_o = mse_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  an = 8'hFF;
    logic [6:0]  seg = 7'h7F;
    logic [31:0] digits;
    logic [7:0]  blank_mask, err_mask;
    logic [5:0]  minutes, seconds;
    logic        time_valid, frame_valid, frame_tick, multi_sel_err;

    int checks = 0;
    int errors = 0;
    int ticks = 0;
    int mses = 0;
    int tick_base, mse_base;

    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk_i(clk), .reset_i(reset), .an_i(an), .seg_i(seg),
        .digits_o(digits), .blank_mask_o(blank_mask), .err_mask_o(err_mask),
        .minutes_o(minutes), .seconds_o(seconds), .time_valid_o(time_valid),
        .frame_valid_o(frame_valid), .frame_tick_o(frame_tick),
        .multi_sel_err_o(multi_sel_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick) ticks++;
        if (multi_sel_err) mses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; holds the values for n rising edges.
    task automatic dwell(input logic [7:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int anode, input logic [6:0] s);
        dwell(~(8'(8'h1 << anode)), s, 8);
    endtask

    task automatic idle(input int n);
        dwell(8'hFF, 7'h7F, n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_digits", digits, 32'hFFFF_FFFF);
        check("rst_blank", {24'd0, blank_mask}, 32'hFF);
        check("rst_err", {24'd0, err_mask}, 32'h0);
        check("rst_min", {26'd0, minutes}, 32'd0);
        check("rst_sec", {26'd0, seconds}, 32'd0);
        check("rst_tv", {31'd0, time_valid}, 32'd0);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        idle(4);

        // Full scan 2,1,5,3,0,0,0,0 then anode 0 repeats
        tick_base = ticks;
        digit(0, lut[2]); digit(1, lut[1]); digit(2, lut[5]); digit(3, lut[3]);
        for (int i = 4; i < 8; i++) digit(i, lut[0]);
        digit(0, lut[2]);
        idle(4);
        check("full_ticks", ticks - tick_base, 32'd1);
        check("full_digits", digits, 32'h0000_3512);
        check("full_min", {26'd0, minutes}, 32'd35);
        check("full_sec", {26'd0, seconds}, 32'd12);
        check("full_tv", {31'd0, time_valid}, 32'd1);
        check("full_blank", {24'd0, blank_mask}, 32'h00);
        check("full_fv", {31'd0, frame_valid}, 32'd1);

        // Set-mode partial scan; the leading anode-0 capture also commits since slot 0 is still seen
        tick_base = ticks;
        digit(0, lut[0]); digit(1, lut[4]); digit(2, lut[5]); digit(3, lut[1]);
        idle(32);
        digit(0, lut[0]);
        idle(4);
        check("part_ticks", ticks - tick_base, 32'd2);
        check("part_digits", digits, 32'hFFFF_1540);
        check("part_blank", {24'd0, blank_mask}, 32'hF0);
        check("part_min", {26'd0, minutes}, 32'd15);
        check("part_sec", {26'd0, seconds}, 32'd40);
        check("part_fv", {31'd0, frame_valid}, 32'd1);

        // Dwells one cycle short of settling, then a double-anode dwell
        tick_base = ticks;
        mse_base  = mses;
        for (int k = 0; k < 4; k++) dwell(~(8'(8'h1 << (k % 2))), lut[8], 3);
        idle(8);
        check("short_ticks", ticks - tick_base, 32'd0);
        dwell(8'b1111_1100, lut[8], 8);
        idle(8);
        check("multi_pulse", mses - mse_base, 32'd1);
        check("multi_ticks", ticks - tick_base, 32'd0);

        // Undecodable digit 3, blanks on 4..7
        tick_base = ticks;
        digit(0, lut[6]); digit(1, lut[4]); digit(2, lut[2]); digit(3, 7'b0101010);
        for (int i = 4; i < 8; i++) digit(i, 7'h7F);
        digit(0, lut[6]);
        idle(80);
        check("err_ticks", ticks - tick_base, 32'd2);
        check("err_digits", digits, 32'hFFFF_E246);
        check("err_mask", {24'd0, err_mask}, 32'h08);
        check("err_blank", {24'd0, blank_mask}, 32'hF0);
        check("err_tv", {31'd0, time_valid}, 32'd0);
        check("to_fv_before", {31'd0, frame_valid}, 32'd1);

        // Timeout: frame_valid drops, committed data held
        idle(30);
        check("to_fv_after", {31'd0, frame_valid}, 32'd0);
        check("to_digits", digits, 32'hFFFF_E246);
        check("to_err", {24'd0, err_mask}, 32'h08);

        tick_base = ticks;
        digit(0, lut[9]); digit(1, lut[5]); digit(2, lut[9]); digit(3, lut[5]);
        idle(8);
        check("fresh_fv_mid", {31'd0, frame_valid}, 32'd0);
        digit(0, lut[9]);
        idle(4);
        check("fresh_ticks", ticks - tick_base, 32'd1);
        check("fresh_fv", {31'd0, frame_valid}, 32'd1);
        check("fresh_digits", digits, 32'hFFFF_5959);
        check("fresh_min", {26'd0, minutes}, 32'd59);
        check("fresh_sec", {26'd0, seconds}, 32'd59);

        // Asynchronous reset while digit 2 settles
        digit(0, lut[7]); digit(1, lut[8]);
        dwell(8'b1111_1011, lut[3], 2);
        #3;
        reset = 1'b1;
        #1;
        check("arst_digits", digits, 32'hFFFF_FFFF);
        check("arst_blank", {24'd0, blank_mask}, 32'hFF);
        check("arst_fv", {31'd0, frame_valid}, 32'd0);
        check("arst_tv", {31'd0, time_valid}, 32'd0);
        check("arst_min", {26'd0, minutes}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick_base = ticks;
        idle(4);
        digit(0, lut[1]); digit(1, lut[2]); digit(2, lut[3]); digit(3, lut[4]);
        idle(8);
        check("post_rst_noticks", ticks - tick_base, 32'd0);
        check("post_rst_fv", {31'd0, frame_valid}, 32'd0);
        digit(0, lut[1]);
        idle(4);
        check("post_rst_ticks", ticks - tick_base, 32'd1);
        check("post_rst_digits", digits, 32'hFFFF_4321);
        check("post_rst_min", {26'd0, minutes}, 32'd43);
        check("post_rst_sec", {26'd0, seconds}, 32'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
